// File: rtl/record_updater.sv
// Reaction-time record judge: snapshots a finished measurement, compares it
// digit by digit (MSD first) against the stored record and issues the memory write.
module record_updater #(
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic               ck,
  input  logic               reset,
  input  logic               start,
  input  logic               valid_meas,
  input  logic [DIGIT_W-1:0] cnt0,
  input  logic [DIGIT_W-1:0] cnt1,
  input  logic [DIGIT_W-1:0] cnt2,
  input  logic [DIGIT_W-1:0] cnt3,
  input  logic [DIGIT_W-1:0] rec0,
  input  logic [DIGIT_W-1:0] rec1,
  input  logic [DIGIT_W-1:0] rec2,
  input  logic [DIGIT_W-1:0] rec3,
  output logic               write_enable,
  output logic [DIGIT_W-1:0] wr0,
  output logic [DIGIT_W-1:0] wr1,
  output logic [DIGIT_W-1:0] wr2,
  output logic [DIGIT_W-1:0] wr3,
  output logic               busy,
  output logic               done,
  output logic               new_record,
  output logic               bcd_err
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         idx;
  logic [DIGIT_W-1:0] wr_sel;
  logic [DIGIT_W-1:0] rec_sel;
  logic               cnt_bad;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > MAX_D;
  endfunction

  always_comb begin
    cnt_bad = digit_bad(cnt0) | digit_bad(cnt1) | digit_bad(cnt2) | digit_bad(cnt3);
  end

  // Digit under comparison: snapshot digit against the live record digit.
  always_comb begin
    wr_sel  = wr0;
    rec_sel = rec0;
    case (idx)
      2'd1: begin wr_sel = wr1; rec_sel = rec1; end
      2'd2: begin wr_sel = wr2; rec_sel = rec2; end
      2'd3: begin wr_sel = wr3; rec_sel = rec3; end
      default: begin wr_sel = wr0; rec_sel = rec0; end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 2'd3;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      new_record   <= 1'b0;
      bcd_err      <= 1'b0;
      wr0          <= '0;
      wr1          <= '0;
      wr2          <= '0;
      wr3          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr0        <= cnt0;
            wr1        <= cnt1;
            wr2        <= cnt2;
            wr3        <= cnt3;
            new_record <= 1'b0;
            bcd_err    <= cnt_bad;
            busy       <= 1'b1;
            idx        <= 2'd3;
            // Rejected measurements skip the compare and finish without a write.
            if (cnt_bad || !valid_meas) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= CMP;
            end
          end
        end
        CMP: begin
          if (wr_sel < rec_sel) begin
            state        <= FINISH;
            done         <= 1'b1;
            write_enable <= 1'b1;
            new_record   <= 1'b1;
          end else if (wr_sel > rec_sel) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (idx != 2'd0) begin
            idx <= idx - 2'd1;
          end else begin
            // All four digits equal: a tie does not replace the record.
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state        <= IDLE;
          idx          <= 2'd3;
          busy         <= 1'b0;
          done         <= 1'b0;
          write_enable <= 1'b0;
        end
        default: begin
          state <= IDLE;
          idx   <= 2'd3;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_updater.sv
// Bench for record_updater: a behavioural record memory plus an integer-level
// model of the "faster time wins" rule, driven with directed and random measurements.
module tb_record_updater;

  logic       ck = 1'b0;
  logic       reset;
  logic       start;
  logic       valid_meas;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic [3:0] rec0, rec1, rec2, rec3;
  logic [3:0] wr0, wr1, wr2, wr3;
  logic       write_enable, busy, done, new_record, bcd_err;

  logic [3:0] mem [4];
  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int we_cnt       = 0;
  int exp_rec      = 9999;

  always #5 ck = ~ck;

  record_updater #(.DIGIT_W(4), .MAX_DIGIT(9)) dut (
    .ck(ck), .reset(reset), .start(start), .valid_meas(valid_meas),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .rec0(rec0), .rec1(rec1), .rec2(rec2), .rec3(rec3),
    .write_enable(write_enable),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .busy(busy), .done(done), .new_record(new_record), .bcd_err(bcd_err)
  );

  // Record memory: resets to 9999, captures wr* when write_enable is high.
  always @(posedge ck) begin
    if (reset) begin
      mem <= '{4'd9, 4'd9, 4'd9, 4'd9};
    end else if (write_enable) begin
      mem[0] <= wr0; mem[1] <= wr1; mem[2] <= wr2; mem[3] <= wr3;
    end
  end
  assign rec0 = mem[0];
  assign rec1 = mem[1];
  assign rec2 = mem[2];
  assign rec3 = mem[3];

  always @(negedge ck) begin
    if (done === 1'b1) done_cnt++;
    if (write_enable === 1'b1) we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mem_val();
    return int'(mem[3]) * 1000 + int'(mem[2]) * 100 + int'(mem[1]) * 10 + int'(mem[0]);
  endfunction

  task automatic pulse_reset();
    @(negedge ck);
    reset = 1'b1;
    start = 1'b0;
    @(posedge ck); #1;
    reset = 1'b0;
    exp_rec = 9999;
  endtask

  // One measurement; poke drives extra start pulses during CMP and FINISH.
  task automatic evaluate(input int d3, input int d2, input int d1, input int d0,
                          input bit vld, input bit poke);
    int m[4];
    int r[4];
    int meas, k, cyc, dc0, wc0;
    bit bad, exp_we;
    logic [15:0] exp_wr;
    m[0] = d0; m[1] = d1; m[2] = d2; m[3] = d3;
    r[3] = (exp_rec / 1000) % 10;
    r[2] = (exp_rec / 100) % 10;
    r[1] = (exp_rec / 10) % 10;
    r[0] = exp_rec % 10;
    bad = (d0 > 9) || (d1 > 9) || (d2 > 9) || (d3 > 9);
    meas = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    exp_wr = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    k = 0;
    exp_we = 1'b0;
    if (!bad && vld) begin
      exp_we = (meas < exp_rec);
      for (int i = 3; i >= 0; i--) begin
        k++;
        if (m[i] != r[i]) break;
      end
    end
    dc0 = done_cnt;
    wc0 = we_cnt;

    @(negedge ck);
    cnt3 = 4'(d3); cnt2 = 4'(d2); cnt1 = 4'(d1); cnt0 = 4'(d0);
    valid_meas = vld;
    start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    cnt0 = 4'($urandom); cnt1 = 4'($urandom); cnt2 = 4'($urandom); cnt3 = 4'($urandom);
    check("busy_after_start", busy, 1);

    cyc = 0;
    while (done !== 1'b1 && cyc < 8) begin
      start = poke && (cyc == 0);
      @(posedge ck); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, k);
    check("write_enable", write_enable, exp_we);
    check("wr_snapshot", {wr3, wr2, wr1, wr0}, exp_wr);
    check("new_record", new_record, exp_we);
    check("bcd_err", bcd_err, bad);
    check("busy_finish", busy, 1);

    if (poke) start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("we_idle", write_enable, 0);
    check("new_record_hold", new_record, exp_we);
    check("bcd_err_hold", bcd_err, bad);
    @(posedge ck); #1;
    if (exp_we) exp_rec = meas;
    check("record_mem", mem_val(), exp_rec);
    check("wr_hold", {wr3, wr2, wr1, wr0}, exp_wr);
    check("done_pulses", done_cnt - dc0, 1);
    check("we_pulses", we_cnt - wc0, exp_we);
  endtask

  initial begin
    int dc0, wc0;
    int d[4];
    int r[4];
    int p;
    reset = 1'b1;
    start = 1'b0;
    valid_meas = 1'b1;
    cnt0 = '0; cnt1 = '0; cnt2 = '0; cnt3 = '0;
    repeat (3) @(posedge ck);
    #1;
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_new_record", new_record, 0);
    check("rst_bcd_err", bcd_err, 0);
    check("rst_wr", {wr3, wr2, wr1, wr0}, 0);
    reset = 1'b0;
    exp_rec = 9999;

    evaluate(0, 2, 3, 4, 1, 0);   // beats 9999 at the first digit
    evaluate(0, 2, 5, 0, 1, 0);   // slower, decided at digit 1
    evaluate(0, 2, 3, 4, 1, 0);   // tie
    evaluate(0, 2, 3, 3, 1, 0);   // new record decided at digit 0
    evaluate(0, 10, 1, 2, 1, 0);  // illegal digit
    evaluate(1, 2, 3, 4, 0, 0);   // false start
    evaluate(15, 2, 3, 4, 0, 0);  // both faults
    evaluate(0, 2, 3, 3, 1, 1);   // tie with extra starts while busy
    evaluate(0, 1, 0, 0, 1, 1);   // record with extra starts while busy

    // Back-to-back: start held high, so the first IDLE cycle after FINISH is accepted.
    dc0 = done_cnt;
    @(negedge ck);
    cnt3 = 4'd1; cnt2 = 4'd1; cnt1 = 4'd1; cnt0 = 4'd1;
    valid_meas = 1'b0;
    start = 1'b1;
    @(posedge ck); #1;
    check("b2b_done1", done, 1);
    @(posedge ck); #1;
    check("b2b_idle", busy, 0);
    @(posedge ck); #1;
    check("b2b_done2", done, 1);
    start = 1'b0;
    @(posedge ck); #1;
    check("b2b_pulses", done_cnt - dc0, 2);
    valid_meas = 1'b1;

    // Reset landing on the edge where CMP decides a write.
    pulse_reset();
    wc0 = we_cnt;
    @(negedge ck);
    cnt3 = 4'd0; cnt2 = 4'd2; cnt1 = 4'd3; cnt0 = 4'd4;
    start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge ck); #1;
    reset = 1'b0;
    check("rstmid_we", write_enable, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_new_record", new_record, 0);
    check("rstmid_wr", {wr3, wr2, wr1, wr0}, 0);
    repeat (4) @(posedge ck);
    #1;
    check("rstmid_we_pulses", we_cnt - wc0, 0);
    check("rstmid_record", mem_val(), 9999);
    exp_rec = 9999;
    evaluate(0, 2, 3, 4, 1, 0);

    for (int it = 0; it < 160; it++) begin
      if (it % 40 == 39) pulse_reset();
      r[3] = (exp_rec / 1000) % 10;
      r[2] = (exp_rec / 100) % 10;
      r[1] = (exp_rec / 10) % 10;
      r[0] = exp_rec % 10;
      p = $urandom_range(0, 4);
      for (int i = 3; i >= 0; i--) begin
        if (3 - i < p) d[i] = r[i];
        else d[i] = $urandom_range(0, 9);
      end
      if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 3)] = $urandom_range(10, 15);
      evaluate(d[3], d[2], d[1], d[0], ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/record_updater.md
Name: record_updater

Overview:
- Decides whether a finished reaction-time measurement beats the stored best record, and issues the single-cycle write that updates the record memory.
- Reads the four stored record digits (rec0..rec3) and the four measured counter digits (cnt0..cnt3). Compares them as BCD, most significant digit first, one digit per clock.
- Drives the record memory's write_enable and the digits it stores. Sits between the game controller (which issues start) and the record memory.

Parameters:
- DIGIT_W, 4, width of one BCD digit.
- MAX_DIGIT, 9, largest legal digit value; any measured digit above it rejects the measurement.

Ports:
- ck  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: measurement finished, evaluate it
- valid_meas  input  1  measurement is legitimate (not a false start); sampled with start
- cnt0..cnt3  input  DIGIT_W each  measured time digits; cnt3 is the most significant digit
- rec0..rec3  input  DIGIT_W each  stored record digits from the memory; rec3 is the most significant digit
- write_enable  output  1  one-cycle pulse to the memory: store wr0..wr3
- wr0..wr3  output  DIGIT_W each  snapshot of cnt0..cnt3 taken at start; connect to the memory's data inputs
- busy  output  1  high from the accepted start until the FINISH cycle inclusive
- done  output  1  one-cycle pulse: evaluation complete
- new_record  output  1  last evaluation wrote a new record; held until the next accepted start
- bcd_err  output  1  last accepted start carried a digit > MAX_DIGIT; held until the next accepted start

Behaviour:
- All outputs registered.
- Reset (synchronous): state IDLE, digit index 3. write_enable, busy, done, new_record and bcd_err are 0. wr0..wr3 are 0.
- States: IDLE, CMP, FINISH.
- IDLE:
  - start=1 at edge E0 is accepted.
  - At E0: snapshot cnt0..cnt3 into wr0..wr3, clear new_record and bcd_err, set busy=1.
  - If valid_meas=0 or any cnt digit > MAX_DIGIT: go to FINISH with write_enable=0. bcd_err=1 only for the digit fault; valid_meas=0 alone does not set it. If both apply, bcd_err=1.
  - Otherwise: go to CMP with index=3.
- CMP: each edge compares wr[index] against live rec[index].
  - wr < rec: go to FINISH, write_enable=1, new_record=1.
  - wr > rec: go to FINISH, write_enable=0.
  - Equal, index>0: decrement index, stay in CMP.
  - Equal, index=0 (tie): go to FINISH, no write. A tie is not a record.
- FINISH: lasts exactly one cycle with done=1. write_enable is high in this same cycle only if a write was decided. The next edge returns to IDLE, with busy=0 and write_enable=0.
- Timing: if k digits are examined (1..4), FINISH starts at edge E(k). A rejected measurement reaches FINISH at E0, so done is high in the cycle after E0. The memory captures wr0..wr3 at edge E(k+1).
- start is ignored while busy=1, including during the FINISH cycle. A start in the first IDLE cycle after FINISH is accepted.
- wr0..wr3 stay stable from E0 until the next accepted start, so the memory write is immune to the counter changing after start.
- rec inputs are read live. The memory changes them only via this block's write, which happens after the decision.
- Reset asserted in any state: next edge returns to IDLE with all outputs at their reset values. A pending write is abandoned; write_enable must never pulse after reset.
- Only the digit-validity check and the digit compare use magnitude logic: unsigned compares on DIGIT_W bits, no arithmetic.

Test Plan:
- After reset (memory holds 9999), cnt3..cnt0=0,2,3,4, valid_meas=1, start pulse -> done and write_enable high in the cycle after E1; wr=0234; new_record=1; memory reads 0234 after E2.
- Record 0234, measure 0250 -> digits 3 and 2 equal, digit 1 5>3 -> done at E3, write_enable never high, new_record=0, record stays 0234.
- Record 0234, measure 0234 (tie) -> done at E4, no write. Then measure 0233 -> done and write at E4, record becomes 0233.
- Measure 0,A,1,2 with valid_meas=1 -> done in the cycle after E0, bcd_err=1, no write. A separate start with valid_meas=0 and legal digits -> done after E0, bcd_err=0, no write.
- Second start pulse while busy (during CMP and during FINISH) -> ignored: exactly one done per accepted start, and the snapshot is unchanged.
- Reset asserted in the cycle where CMP decides wr<rec -> write_enable stays 0, state IDLE, record unchanged (memory reset restores 9999). A following start evaluates normally.
